ram_fifo: RTL
=============

RAM_FIFO -- requirements
Module: ram_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 4, capacity in words; power of two, >= 2.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_data  input  WIDTH  write word from the upstream pattern generator.
REQ-006 in_valid  input  1  in_data is presented for writing.
REQ-007 in_ready  output  1  FIFO can accept a word this cycle.
REQ-008 out_data  output  WIDTH  head word, registered (drives led downstream).
REQ-009 out_valid  output  1  out_data holds a valid head word.
REQ-010 out_ready  input  1  consumer takes the head word this cycle.
REQ-011 level  output  $clog2(DEPTH)+1  number of words held, including the output register.

Function
REQ-012 The block SHALL store words in an inferred RAM array of DEPTH x WIDTH with a registered read port (iCE40 BRAM-mappable), plus one output register.
REQ-013 Push SHALL occur on an edge where in_valid && in_ready; pop SHALL occur on an edge where out_valid && out_ready.
REQ-014 in_ready SHALL equal (level != DEPTH), decoded combinationally from the registered level only, with no dependency on out_ready.
REQ-015 While level == DEPTH, a push SHALL be refused even if a pop occurs in the same cycle; in_data is ignored.
REQ-016 Write and read pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 with no special case.
REQ-017 level SHALL +1 on push only, -1 on pop only, and stay unchanged on simultaneous push and pop; it never exceeds DEPTH and never underflows.
REQ-018 Latency: a word pushed into an empty FIFO at edge N SHALL have out_valid=1 and out_data=that word after edge N+1.
REQ-019 The output register SHALL refill from RAM on the edge after a pop when words remain; back-to-back pops SHALL sustain one word per cycle once out_valid is high and RAM holds data.
REQ-020 While out_valid && !out_ready, out_data and out_valid SHALL hold stable.
REQ-021 out_valid SHALL fall after the edge that pops the last word; out_data then holds its last value.
REQ-022 Words SHALL emerge in push order with no loss, duplication or reordering across pointer wrap.
REQ-023 A push to an empty FIFO with out_ready=1 SHALL NOT bypass RAM; the REQ-018 latency applies.

Reset
REQ-024 While rst_n=0: pointers=0, level=0, out_valid=0, out_data=0, read-issue state cleared; RAM contents are unspecified and unread until written.
REQ-025 Reset assertion mid-operation SHALL discard all contents immediately (asynchronous); first push after deassertion behaves as into an empty FIFO.
REQ-026 in_ready SHALL read 1 from the first edge after rst_n deasserts.

Verification (WIDTH=8, DEPTH=4)
REQ-027 Reset, push 0x11 with out_ready=0 -> level=1; out_valid=1, out_data=0x11 one edge after push; held stable 5 cycles.
REQ-028 Push 0x00..0x03 with out_ready=0 -> level=4, in_ready=0; extra push of 0x04 refused; then pop 4 -> 0x00,0x01,0x02,0x03, level=0, out_valid=0.
REQ-029 Continuous in_valid with incrementing data from 0, out_ready=1 -> output 0,1,2,... one per cycle after fill, level steady, 20 words, no gaps after start.
REQ-030 Full FIFO, in_valid=1 and out_ready=1 same cycle -> only pop occurs, level 4->3, in_ready=1 next cycle.
REQ-031 Random in_valid/out_ready 1000 cycles vs reference queue model -> identical order, level matches model every cycle, pointers wrap >=100 times.
REQ-032 Fill with 3 words, assert rst_n=0 mid-cycle -> level=0, out_valid=0 immediately; after release push 0xAA -> out_data=0xAA one edge later.

Source files
------------

// File: rtl/ram_fifo.sv
// Synchronous FIFO: inferred DEPTH x WIDTH RAM whose registered read port is the output register.
// A word written at edge N is presented at edge N+1. in_ready depends only on the registered level.
module ram_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [LW-1:0]    ram_count;
   logic [LW-1:0]    level_nxt;
   logic             push;
   logic             pop;
   logic             load;

   assign in_ready  = (level != LW'(DEPTH));
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   // Words still in RAM that have not yet been moved into the output register.
   assign ram_count = level - LW'(out_valid);
   assign load      = (ram_count != '0) && (!out_valid || out_ready);

   always_comb begin
      level_nxt = level;
      if (push && !pop)
         level_nxt = level + LW'(1);
      else if (!push && pop)
         level_nxt = level - LW'(1);
   end

   // No reset on the array so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         level <= level_nxt;
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (load) begin
            out_data  <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + PW'(1);
            out_valid <= 1'b1;
         end else if (pop) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
